// File: rtl/button_conditioner.sv
// Conditions three raw game buttons: two-flop synchronizer, per-button stability debouncer,
// press-event strobes, and pending-press latches that hold short presses until the next game tick.
module button_conditioner #(
    parameter int DB_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_tick,
    input  logic       start_raw,
    input  logic       up_raw,
    input  logic       down_raw,
    output logic       button_start,
    output logic       button_up,
    output logic       button_down,
    output logic [2:0] press_event
);

    // Bit order everywhere: [0] start, [1] up, [2] down.
    localparam logic [8:0] DB_MAX_W = 9'(DB_MAX);

    logic [2:0]      raw;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0][7:0] cnt_q;
    logic [2:0][7:0] cnt_d;
    logic [2:0][8:0] cnt_inc;
    logic [2:0]      deb_q;
    logic [2:0]      deb_d;
    logic [2:0]      rise;
    logic [2:0]      press_q;
    logic [2:0]      press_d;
    logic [1:0]      pend_q;
    logic [1:0]      pend_d;
    logic            tick0;
    logic            unused_tick1;

    assign raw          = {down_raw, up_raw, start_raw};
    assign tick0        = game_tick[0];
    assign unused_tick1 = game_tick[1];

    always_comb begin
        cnt_inc = '0;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_inc[i] = {1'b0, cnt_q[i]} + 9'd1;
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_inc[i] == DB_MAX_W) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_inc[i][7:0];
            end
        end
    end

    assign rise    = deb_d & ~deb_q;
    assign press_d = rise;

    // A rise at the same edge as a tick keeps the flag set so the press is not lost.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 2; i++) begin
            if (rise[i]) begin
                pend_d[i] = 1'b1;
            end else if (tick0) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            deb_q   <= '0;
            press_q <= '0;
            pend_q  <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            press_q <= press_d;
            pend_q  <= pend_d;
        end
    end

    assign button_start = deb_q[0] | pend_q[0];
    assign button_up    = deb_q[1] | pend_q[1];
    assign button_down  = deb_q[2];
    assign press_event  = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and lightly randomised scenarios for button_conditioner at DB_MAX=4; expected output
// vectors {press_event, down, up, start} are derived from edge-count timelines.
module tb_button_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rst;
    logic [1:0] game_tick;
    logic       start_raw;
    logic       up_raw;
    logic       down_raw;
    logic       button_start;
    logic       button_up;
    logic       button_down;
    logic [2:0] press_event;

    int vectors;
    int miscompares;
    logic [5:0] exp_q[$];

    button_conditioner #(.DB_MAX(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .game_tick   (game_tick),
        .start_raw   (start_raw),
        .up_raw      (up_raw),
        .down_raw    (down_raw),
        .button_start(button_start),
        .button_up   (button_up),
        .button_down (button_down),
        .press_event (press_event)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle n: inputs set before edge n, outputs sampled on the falling edge after edge n.
    task automatic test_reset();
        logic [5:0] got, exp;
        for (int n = 0; n <= 10; n++) begin
            rst       = (n <= 2);
            game_tick = (n <= 2) ? 2'b11 : 2'b00;
            start_raw = 1'b1;
            up_raw    = 1'b1;
            down_raw  = 1'b1;
            exp = {(n == 8) ? 3'b111 : 3'b000, n >= 8, n >= 8, n >= 8};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    task automatic test_latency();
        logic [5:0] got, exp;
        for (int n = 0; n <= 18; n++) begin
            rst       = (n == 0);
            game_tick = 2'b00;
            start_raw = 1'b0;
            up_raw    = (n >= 10);
            down_raw  = 1'b0;
            exp = {(n == 15) ? 3'b010 : 3'b000, 1'b0, n >= 15, 1'b0};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL latency cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    // A short glitch, one low cycle, then a steady hold: the hold must take the full latency.
    task automatic test_glitch();
        logic [5:0] got, exp;
        int len;
        len = $urandom_range(1, DB - 1);
        for (int n = 0; n <= 11 + len; n++) begin
            rst       = (n == 0);
            game_tick = 2'b00;
            start_raw = 1'b0;
            up_raw    = (n >= 2 && n < 2 + len) || (n >= 3 + len);
            down_raw  = 1'b0;
            exp = {(n == 8 + len) ? 3'b010 : 3'b000, 1'b0, n >= 8 + len, 1'b0};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL glitch len %0d cycle %0d: got %b expected %b", len, n, got, exp);
            end
        end
    endtask

    task automatic test_pending();
        logic [5:0] got, exp;
        int t;
        t = 13 + $urandom_range(2, 20);
        for (int n = 0; n <= t + 3; n++) begin
            rst       = (n == 0);
            game_tick = {1'b0, n == t};
            start_raw = 1'b0;
            up_raw    = (n >= 2 && n <= 7);
            down_raw  = 1'b0;
            exp = {(n == 7) ? 3'b010 : 3'b000, 1'b0, n >= 7 && n < t, 1'b0};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL pending tick %0d cycle %0d: got %b expected %b", t, n, got, exp);
            end
        end
    endtask

    task automatic test_down_hold();
        logic [5:0] got, exp;
        for (int n = 0; n <= 49; n++) begin
            rst       = (n == 0);
            game_tick = {1'($urandom_range(0, 1)), n >= 10 && (n - 10) % 8 == 0};
            start_raw = 1'b0;
            up_raw    = 1'b0;
            down_raw  = (n >= 2 && n <= 40);
            exp = {(n == 7) ? 3'b100 : 3'b000, n >= 7 && n < 46, 1'b0, 1'b0};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL down_hold cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    task automatic test_start_coincide();
        logic [5:0] got, exp;
        for (int n = 0; n <= 23; n++) begin
            rst       = (n == 0);
            game_tick = {1'($urandom_range(0, 1)), n == 7 || n == 20};
            start_raw = (n >= 2 && n <= 7);
            up_raw    = 1'b0;
            down_raw  = 1'b0;
            exp = {(n == 7) ? 3'b001 : 3'b000, 1'b0, 1'b0, n >= 7 && n < 20};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL start_coincide cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    // Reset lands with the up counter at 2 and a start press pending.
    task automatic test_reset_mid();
        logic [5:0] got, exp;
        for (int n = 0; n <= 23; n++) begin
            rst       = (n == 0 || n == 14);
            game_tick = 2'b00;
            start_raw = (n >= 2 && n <= 7);
            up_raw    = (n >= 10);
            down_raw  = 1'b0;
            exp = {(n == 7) ? 3'b001 : (n == 20) ? 3'b010 : 3'b000,
                   1'b0, n >= 20, n >= 7 && n < 14};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_mid cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got, exp;
        for (int n = 0; n <= 11; n++) begin
            rst       = (n == 0);
            game_tick = 2'b00;
            start_raw = (n >= 3);
            up_raw    = (n >= 2);
            down_raw  = (n >= 2);
            exp = {(n == 7) ? 3'b110 : (n == 8) ? 3'b001 : 3'b000, n >= 7, n >= 7, n >= 8};
            exp_q.push_back(exp);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {press_event, button_down, button_up, button_start};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", n, got, exp);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        game_tick   = 2'b00;
        start_raw   = 1'b0;
        up_raw      = 1'b0;
        down_raw    = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_glitch();
        test_pending();
        test_down_hold();
        test_start_coincide();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
